// File: rtl/ysyx_22051013_axi_router_if.sv
// AXI4 channel bundle for the router. Every field is packed N lanes wide,
// lane i occupying bits [i*W +: W]; N=1 gives a plain single AXI port.
interface ysyx_22051013_axi_router_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 5
);
  // write address
  logic [N*ID_W-1:0]       aw_id;
  logic [N*ADDR_W-1:0]     aw_addr;
  logic [N*8-1:0]          aw_len;
  logic [N*3-1:0]          aw_size;
  logic [N*2-1:0]          aw_burst;
  logic [N-1:0]            aw_valid;
  logic [N-1:0]            aw_ready;
  // write data
  logic [N*DATA_W-1:0]     w_data;
  logic [N*(DATA_W/8)-1:0] w_strb;
  logic [N-1:0]            w_last;
  logic [N-1:0]            w_valid;
  logic [N-1:0]            w_ready;
  // write response
  logic [N*ID_W-1:0]       b_id;
  logic [N*2-1:0]          b_resp;
  logic [N-1:0]            b_valid;
  logic [N-1:0]            b_ready;
  // read address
  logic [N*ID_W-1:0]       ar_id;
  logic [N*ADDR_W-1:0]     ar_addr;
  logic [N*8-1:0]          ar_len;
  logic [N*3-1:0]          ar_size;
  logic [N*2-1:0]          ar_burst;
  logic [N-1:0]            ar_valid;
  logic [N-1:0]            ar_ready;
  // read data
  logic [N*ID_W-1:0]       r_id;
  logic [N*DATA_W-1:0]     r_data;
  logic [N*2-1:0]          r_resp;
  logic [N-1:0]            r_last;
  logic [N-1:0]            r_valid;
  logic [N-1:0]            r_ready;

  // The side that issues requests
  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  // The side that serves requests
  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/ysyx_22051013_axi_router.sv
// 1-to-NS AXI4 address router with one outstanding write and one outstanding
// read, plus a built-in error slave (DECERR) for unmapped addresses.
// SLV_BASE/SLV_MASK list slaves left to right: the leftmost ADDR_W-bit word
// describes slave 0. Routing is purely combinational (zero added latency);
// only the selection, id, len and beat count are registered.
module ysyx_22051013_axi_router #(
  parameter int NS     = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 5,
  parameter logic [NS*ADDR_W-1:0] SLV_BASE = {64'h0200_0000, 64'h8000_0000},
  parameter logic [NS*ADDR_W-1:0] SLV_MASK = {64'hFFFF_FFFF_FFFF_0000, 64'hFFFF_FFFF_8000_0000}
) (
  input logic clk,
  input logic rst_n,
  ysyx_22051013_axi_router_if.slave  m,
  ysyx_22051013_axi_router_if.master s
);
  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = $clog2(NS + 1);
  // The error slave takes the index just past the last real slave
  localparam logic [SEL_W-1:0] ERR_SEL = SEL_W'(NS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Lowest matching index wins, so scan from the top down and let lower
  // indices overwrite higher ones.
  function automatic logic [SEL_W-1:0] decode(input logic [ADDR_W-1:0] addr);
    logic [SEL_W-1:0] sel;
    sel = ERR_SEL;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[(NS-1-i)*ADDR_W +: ADDR_W]) == SLV_BASE[(NS-1-i)*ADDR_W +: ADDR_W])
        sel = SEL_W'(i);
    end
    return sel;
  endfunction

  logic [SEL_W-1:0] aw_dec, ar_dec;
  assign aw_dec = decode(m.aw_addr);
  assign ar_dec = decode(m.ar_addr);

  w_state_t         w_state_reg;
  logic [SEL_W-1:0] w_sel_reg;
  logic [ID_W-1:0]  w_id_reg;

  r_state_t         r_state_reg;
  logic [SEL_W-1:0] r_sel_reg;
  logic [ID_W-1:0]  r_id_reg;
  logic [7:0]       r_len_reg;
  logic [7:0]       r_cnt_reg;

  logic              aw_ready_int, w_ready_int, b_valid_int;
  logic [ID_W-1:0]   b_id_int;
  logic [1:0]        b_resp_int;
  logic              ar_ready_int, r_valid_int, r_last_int;
  logic [ID_W-1:0]   r_id_int;
  logic [DATA_W-1:0] r_data_int;
  logic [1:0]        r_resp_int;

  // Master-facing write path: pick the addressed (IDLE) or latched slave,
  // or the error slave; everything is held at zero while in reset.
  always_comb begin
    aw_ready_int = 1'b0;
    w_ready_int  = 1'b0;
    b_valid_int  = 1'b0;
    b_id_int     = '0;
    b_resp_int   = 2'b00;
    if (rst_n) begin
      case (w_state_reg)
        W_IDLE: begin
          if (aw_dec == ERR_SEL) aw_ready_int = 1'b1;
          for (int i = 0; i < NS; i++)
            if (aw_dec == SEL_W'(i)) aw_ready_int = s.aw_ready[i];
        end
        W_DATA: begin
          if (w_sel_reg == ERR_SEL) w_ready_int = 1'b1;
          for (int i = 0; i < NS; i++)
            if (w_sel_reg == SEL_W'(i)) w_ready_int = s.w_ready[i];
        end
        W_RESP: begin
          if (w_sel_reg == ERR_SEL) begin
            b_valid_int = 1'b1;
            b_id_int    = w_id_reg;
            b_resp_int  = 2'b11;
          end
          for (int i = 0; i < NS; i++) begin
            if (w_sel_reg == SEL_W'(i)) begin
              b_valid_int = s.b_valid[i];
              b_id_int    = s.b_id[i*ID_W +: ID_W];
              b_resp_int  = s.b_resp[i*2 +: 2];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Master-facing read path, same selection scheme as the write path
  always_comb begin
    ar_ready_int = 1'b0;
    r_valid_int  = 1'b0;
    r_id_int     = '0;
    r_data_int   = '0;
    r_resp_int   = 2'b00;
    r_last_int   = 1'b0;
    if (rst_n) begin
      case (r_state_reg)
        R_IDLE: begin
          if (ar_dec == ERR_SEL) ar_ready_int = 1'b1;
          for (int i = 0; i < NS; i++)
            if (ar_dec == SEL_W'(i)) ar_ready_int = s.ar_ready[i];
        end
        R_DATA: begin
          if (r_sel_reg == ERR_SEL) begin
            r_valid_int = 1'b1;
            r_id_int    = r_id_reg;
            r_resp_int  = 2'b11;
            r_last_int  = (r_cnt_reg == r_len_reg);
          end
          for (int i = 0; i < NS; i++) begin
            if (r_sel_reg == SEL_W'(i)) begin
              r_valid_int = s.r_valid[i];
              r_id_int    = s.r_id[i*ID_W +: ID_W];
              r_data_int  = s.r_data[i*DATA_W +: DATA_W];
              r_resp_int  = s.r_resp[i*2 +: 2];
              r_last_int  = s.r_last[i];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m.aw_ready = aw_ready_int;
  assign m.w_ready  = w_ready_int;
  assign m.b_valid  = b_valid_int;
  assign m.b_id     = b_id_int;
  assign m.b_resp   = b_resp_int;
  assign m.ar_ready = ar_ready_int;
  assign m.r_valid  = r_valid_int;
  assign m.r_id     = r_id_int;
  assign m.r_data   = r_data_int;
  assign m.r_resp   = r_resp_int;
  assign m.r_last   = r_last_int;

  // Write FSM: latch target and id on AW, wait for last W, then for B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_reg <= W_IDLE;
      w_sel_reg   <= '0;
      w_id_reg    <= '0;
    end else begin
      case (w_state_reg)
        W_IDLE: if (m.aw_valid && aw_ready_int) begin
          w_sel_reg   <= aw_dec;
          w_id_reg    <= m.aw_id;
          w_state_reg <= W_DATA;
        end
        W_DATA: if (m.w_valid && w_ready_int && m.w_last) w_state_reg <= W_RESP;
        W_RESP: if (b_valid_int && m.b_ready) w_state_reg <= W_IDLE;
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // Read FSM: latch target, id and len on AR; count beats until last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_reg <= R_IDLE;
      r_sel_reg   <= '0;
      r_id_reg    <= '0;
      r_len_reg   <= '0;
      r_cnt_reg   <= '0;
    end else begin
      case (r_state_reg)
        R_IDLE: if (m.ar_valid && ar_ready_int) begin
          r_sel_reg   <= ar_dec;
          r_id_reg    <= m.ar_id;
          r_len_reg   <= m.ar_len;
          r_cnt_reg   <= '0;
          r_state_reg <= R_DATA;
        end
        R_DATA: if (r_valid_int && m.r_ready) begin
          if (r_last_int) begin
            r_cnt_reg   <= '0;
            r_state_reg <= R_IDLE;
          end else begin
            r_cnt_reg <= r_cnt_reg + 8'd1;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  // Slave-facing lanes: only the currently selected lane sees anything;
  // every other lane is driven all-zero.
  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_slv
      logic aw_hit, w_hit, b_hit, ar_hit, r_hit;
      assign aw_hit = rst_n && (w_state_reg == W_IDLE) && (aw_dec    == SEL_W'(gi));
      assign w_hit  = rst_n && (w_state_reg == W_DATA) && (w_sel_reg == SEL_W'(gi));
      assign b_hit  = rst_n && (w_state_reg == W_RESP) && (w_sel_reg == SEL_W'(gi));
      assign ar_hit = rst_n && (r_state_reg == R_IDLE) && (ar_dec    == SEL_W'(gi));
      assign r_hit  = rst_n && (r_state_reg == R_DATA) && (r_sel_reg == SEL_W'(gi));

      assign s.aw_valid[gi]                  = aw_hit & m.aw_valid;
      assign s.aw_id[gi*ID_W +: ID_W]        = aw_hit ? m.aw_id    : '0;
      assign s.aw_addr[gi*ADDR_W +: ADDR_W]  = aw_hit ? m.aw_addr  : '0;
      assign s.aw_len[gi*8 +: 8]             = aw_hit ? m.aw_len   : '0;
      assign s.aw_size[gi*3 +: 3]            = aw_hit ? m.aw_size  : '0;
      assign s.aw_burst[gi*2 +: 2]           = aw_hit ? m.aw_burst : '0;

      assign s.w_valid[gi]                   = w_hit & m.w_valid;
      assign s.w_data[gi*DATA_W +: DATA_W]   = w_hit ? m.w_data : '0;
      assign s.w_strb[gi*STRB_W +: STRB_W]   = w_hit ? m.w_strb : '0;
      assign s.w_last[gi]                    = w_hit & m.w_last;

      assign s.b_ready[gi]                   = b_hit & m.b_ready;

      assign s.ar_valid[gi]                  = ar_hit & m.ar_valid;
      assign s.ar_id[gi*ID_W +: ID_W]        = ar_hit ? m.ar_id    : '0;
      assign s.ar_addr[gi*ADDR_W +: ADDR_W]  = ar_hit ? m.ar_addr  : '0;
      assign s.ar_len[gi*8 +: 8]             = ar_hit ? m.ar_len   : '0;
      assign s.ar_size[gi*3 +: 3]            = ar_hit ? m.ar_size  : '0;
      assign s.ar_burst[gi*2 +: 2]           = ar_hit ? m.ar_burst : '0;

      assign s.r_ready[gi]                   = r_hit & m.r_ready;
    end
  endgenerate
endmodule

// File: tb/tb_ysyx_22051013_axi_router.sv
// Directed bench for the AXI router: decode table, bursts, error slave,
// concurrency, mid-transaction reset and an NS=4 overlap build.
module tb_ysyx_22051013_axi_router;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_22051013_axi_router_if #(.N(1), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) mi ();
  ysyx_22051013_axi_router_if #(.N(2), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) si ();
  ysyx_22051013_axi_router_if #(.N(1), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) mi4 ();
  ysyx_22051013_axi_router_if #(.N(4), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) si4 ();

  ysyx_22051013_axi_router #(.NS(2), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .m(mi), .s(si)
  );

  // slave 1 and slave 2 overlap; slave 2's window lies inside slave 1's
  ysyx_22051013_axi_router #(
    .NS(4), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW),
    .SLV_BASE({64'h0200_0000, 64'h3000_0000, 64'h3000_0000, 64'h8000_0000}),
    .SLV_MASK({64'hFFFF_FFFF_FFFF_0000, 64'hFFFF_FFFF_F000_0000,
               64'hFFFF_FFFF_FF00_0000, 64'hFFFF_FFFF_8000_0000})
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .m(mi4), .s(si4)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  rdy;     // slave aw/ar_ready
    logic [1:0]  exp_v;   // expected slave aw/ar_valid
    logic        exp_rdy; // expected master aw/ar_ready
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    logic [3:0]  exp_v;
    logic        exp_rdy;
  } vec4_t;

  vec_t  vecs[10];
  vec4_t vecs4[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    mi.aw_id = '0; mi.aw_addr = '0; mi.aw_len = '0; mi.aw_size = 3'd3; mi.aw_burst = 2'b01; mi.aw_valid = '0;
    mi.w_data = '0; mi.w_strb = '0; mi.w_last = '0; mi.w_valid = '0; mi.b_ready = '0;
    mi.ar_id = '0; mi.ar_addr = '0; mi.ar_len = '0; mi.ar_size = 3'd3; mi.ar_burst = 2'b01; mi.ar_valid = '0;
    mi.r_ready = '0;
    si.aw_ready = '0; si.w_ready = '0; si.b_id = '0; si.b_resp = '0; si.b_valid = '0;
    si.ar_ready = '0; si.r_id = '0; si.r_data = '0; si.r_resp = '0; si.r_last = '0; si.r_valid = '0;
    mi4.aw_id = '0; mi4.aw_addr = '0; mi4.aw_len = '0; mi4.aw_size = '0; mi4.aw_burst = '0; mi4.aw_valid = '0;
    mi4.w_data = '0; mi4.w_strb = '0; mi4.w_last = '0; mi4.w_valid = '0; mi4.b_ready = '0;
    mi4.ar_id = '0; mi4.ar_addr = '0; mi4.ar_len = '0; mi4.ar_size = '0; mi4.ar_burst = '0; mi4.ar_valid = '0;
    mi4.r_ready = '0;
    si4.aw_ready = '0; si4.w_ready = '0; si4.b_id = '0; si4.b_resp = '0; si4.b_valid = '0;
    si4.ar_ready = '0; si4.r_id = '0; si4.r_data = '0; si4.r_resp = '0; si4.r_last = '0; si4.r_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] exp_addr;
    int beat;
    bit pat[6];

    vecs[0] = '{64'h0000_0000_0200_4000, 2'b11, 2'b01, 1'b1};
    vecs[1] = '{64'h0000_0000_0200_4000, 2'b10, 2'b01, 1'b0};
    vecs[2] = '{64'h0000_0000_8000_1000, 2'b10, 2'b10, 1'b1};
    vecs[3] = '{64'h0000_0000_8000_1000, 2'b01, 2'b10, 1'b0};
    vecs[4] = '{64'h0000_0000_1000_0000, 2'b00, 2'b00, 1'b1};
    vecs[5] = '{64'h0000_0000_0201_0000, 2'b00, 2'b00, 1'b1};
    vecs[6] = '{64'hFFFF_FFFF_8000_0000, 2'b00, 2'b00, 1'b1};
    vecs[7] = '{64'h0000_0000_8000_0000, 2'b11, 2'b10, 1'b1};
    vecs[8] = '{64'h0000_0000_0200_FFFF, 2'b11, 2'b01, 1'b1};
    vecs[9] = '{64'h0000_0000_FFFF_FFFF, 2'b10, 2'b10, 1'b1};

    // si4.ar_ready = 4'b0101: slave 0 and slave 2 ready, slaves 1/3 not
    vecs4[0] = '{64'h0200_0100, 4'b0001, 1'b1};
    vecs4[1] = '{64'h3010_0000, 4'b0010, 1'b0};
    vecs4[2] = '{64'h3F00_0000, 4'b0010, 1'b0};
    vecs4[3] = '{64'h8000_0010, 4'b1000, 1'b0};
    vecs4[4] = '{64'h4000_0000, 4'b0000, 1'b1};

    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // ---- reset: outputs quiet even with everything else asserted ----
    clear_all();
    mi.aw_valid = 1'b1; mi.aw_addr = 64'h0200_4000;
    mi.ar_valid = 1'b1; mi.ar_addr = 64'h8000_1000;
    si.aw_ready = 2'b11; si.ar_ready = 2'b11; si.r_valid = 2'b11; si.b_valid = 2'b11; si.w_ready = 2'b11;
    #7;
    check("rst_m_aw_ready", mi.aw_ready, 1'b0);
    check("rst_m_ar_ready", mi.ar_ready, 1'b0);
    check("rst_s_aw_valid", si.aw_valid, 2'b00);
    check("rst_s_ar_valid", si.ar_valid, 2'b00);
    check("rst_m_r_valid",  mi.r_valid, 1'b0);
    check("rst_m_b_valid",  mi.b_valid, 1'b0);
    check("rst_m_w_ready",  mi.w_ready, 1'b0);
    $display("reset: quiet outputs checked");
    clear_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- decode table (AW and AR driven together, no handshake kept) ----
    for (int i = 0; i < 10; i++) begin
      step();
      mi.aw_addr = vecs[i].addr; mi.ar_addr = vecs[i].addr;
      mi.aw_valid = 1'b1; mi.ar_valid = 1'b1;
      si.aw_ready = vecs[i].rdy; si.ar_ready = vecs[i].rdy;
      #1;
      exp_addr = {vecs[i].exp_v[1] ? vecs[i].addr : 64'h0, vecs[i].exp_v[0] ? vecs[i].addr : 64'h0};
      check("tbl_s_aw_valid", si.aw_valid, vecs[i].exp_v);
      check("tbl_s_ar_valid", si.ar_valid, vecs[i].exp_v);
      check("tbl_m_aw_ready", mi.aw_ready, vecs[i].exp_rdy);
      check("tbl_m_ar_ready", mi.ar_ready, vecs[i].exp_rdy);
      check("tbl_s_aw_addr",  si.aw_addr, exp_addr);
      $display("vec %0d addr=%h slaves=%b ready=%b", i, vecs[i].addr, si.aw_valid, mi.aw_ready);
      mi.aw_valid = 1'b0; mi.ar_valid = 1'b0;
      si.aw_ready = 2'b00; si.ar_ready = 2'b00;
    end

    // ---- 4-beat read burst from slave 1 ----
    step();
    mi.ar_valid = 1'b1; mi.ar_addr = 64'h8000_1000; mi.ar_len = 8'd3; mi.ar_id = 5'd5;
    si.ar_ready = 2'b10;
    #1;
    check("burst_ar_ready", mi.ar_ready, 1'b1);
    check("burst_s_ar_valid", si.ar_valid, 2'b10);
    step();
    mi.ar_valid = 1'b0; si.ar_ready = 2'b00; mi.r_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      si.r_valid = 2'b10;
      si.r_data = {64'hD000_0000_0000_0000 + 64'(b), 64'h0};
      si.r_id = {5'd5, 5'd0};
      si.r_resp = 4'b0000;
      si.r_last = {(b == 3), 1'b0};
      #1;
      check("burst_r_valid", mi.r_valid, 1'b1);
      check("burst_r_data",  mi.r_data, 64'hD000_0000_0000_0000 + 64'(b));
      check("burst_r_last",  mi.r_last, (b == 3));
      check("burst_r_id",    mi.r_id, 5'd5);
      check("burst_s_r_ready", si.r_ready, 2'b10);
      $display("burst beat %0d data=%h last=%b", b, mi.r_data, mi.r_last);
      step();
    end
    si.r_valid = 2'b00; si.r_last = 2'b00; si.r_data = '0; si.r_id = '0;
    mi.r_ready = 1'b0;
    mi.ar_valid = 1'b1; mi.ar_addr = 64'h1000_0000; mi.ar_id = 5'd3; mi.ar_len = 8'd2;
    #1;
    check("burst_back_idle", mi.ar_ready, 1'b1);

    // ---- error-slave read, len=2, with r_ready stalls ----
    step();
    mi.ar_valid = 1'b0; mi.ar_id = 5'd0; mi.ar_len = 8'd7;
    beat = 0;
    for (int c = 0; c < 6; c++) begin
      mi.r_ready = pat[c];
      #1;
      check("err_r_valid", mi.r_valid, 1'b1);
      check("err_r_data",  mi.r_data, 64'h0);
      check("err_r_resp",  mi.r_resp, 2'b11);
      check("err_r_id",    mi.r_id, 5'd3);
      check("err_r_last",  mi.r_last, (beat == 2));
      $display("err read cycle %0d beat %0d ready=%b last=%b", c, beat, pat[c], mi.r_last);
      if (pat[c]) beat++;
      step();
    end
    mi.r_ready = 1'b0;
    #1;
    check("err_r_done", mi.r_valid, 1'b0);
    check("err_r_idle", mi.ar_ready, 1'b1);

    // ---- concurrent AW->slave 0 and AR->slave 1 ----
    step();
    mi.ar_addr = 64'h8000_1000; mi.ar_id = 5'd2; mi.ar_len = 8'd0; mi.ar_valid = 1'b1;
    mi.aw_addr = 64'h0200_4000; mi.aw_id = 5'd7; mi.aw_len = 8'd0; mi.aw_valid = 1'b1;
    si.aw_ready = 2'b01; si.ar_ready = 2'b10;
    #1;
    check("cc_s_aw_valid", si.aw_valid, 2'b01);
    check("cc_s_ar_valid", si.ar_valid, 2'b10);
    check("cc_m_aw_ready", mi.aw_ready, 1'b1);
    check("cc_m_ar_ready", mi.ar_ready, 1'b1);
    step();
    mi.aw_valid = 1'b0; mi.ar_valid = 1'b0;
    mi.aw_addr = 64'h8000_0000; mi.aw_id = 5'd1;
    si.aw_ready = 2'b00; si.ar_ready = 2'b00;
    mi.w_valid = 1'b1; mi.w_data = 64'h1122_3344_5566_7788; mi.w_strb = 8'hFF; mi.w_last = 1'b1;
    si.w_ready = 2'b01;
    si.r_valid = 2'b10; si.r_data = {64'hABCD, 64'h0}; si.r_id = {5'd2, 5'd0}; si.r_last = 2'b10;
    mi.r_ready = 1'b1;
    #1;
    check("cc_s_w_valid", si.w_valid, 2'b01);
    check("cc_s_w_data",  si.w_data, {64'h0, 64'h1122_3344_5566_7788});
    check("cc_s_w_strb",  si.w_strb, 16'h00FF);
    check("cc_m_w_ready", mi.w_ready, 1'b1);
    check("cc_m_r_valid", mi.r_valid, 1'b1);
    check("cc_m_r_data",  mi.r_data, 64'hABCD);
    check("cc_s_aw_quiet", si.aw_valid, 2'b00);
    $display("concurrent: W beat and R beat in the same cycle");
    step();
    mi.w_valid = 1'b0; mi.w_last = 1'b0; si.w_ready = 2'b00;
    si.r_valid = 2'b00; si.r_last = 2'b00; si.r_data = '0; si.r_id = '0; mi.r_ready = 1'b0;
    mi.aw_valid = 1'b1; mi.aw_addr = 64'h0200_4000; si.aw_ready = 2'b11; mi.b_ready = 1'b1;
    #1;
    check("wresp_aw_block", mi.aw_ready, 1'b0);
    check("wresp_s_aw_valid", si.aw_valid, 2'b00);
    check("wresp_w_ready", mi.w_ready, 1'b0);
    check("wresp_b_wait", mi.b_valid, 1'b0);
    step();
    si.b_valid = 2'b01; si.b_id = {5'd0, 5'd7}; si.b_resp = 4'b0000;
    #1;
    check("wresp_b_valid", mi.b_valid, 1'b1);
    check("wresp_b_id",    mi.b_id, 5'd7);
    check("wresp_b_resp",  mi.b_resp, 2'b00);
    check("wresp_aw_still_block", mi.aw_ready, 1'b0);
    check("wresp_s_b_ready", si.b_ready, 2'b01);
    step();
    si.b_valid = 2'b00; si.b_id = '0;
    #1;
    check("after_b_aw_ready", mi.aw_ready, 1'b1);
    check("after_b_s_aw_valid", si.aw_valid, 2'b01);
    mi.aw_valid = 1'b0; si.aw_ready = 2'b00; mi.b_ready = 1'b0;
    $display("concurrent: second AW held off until B completed");

    // ---- error-slave write, 2 beats ----
    step();
    mi.aw_valid = 1'b1; mi.aw_addr = 64'h1000_0000; mi.aw_id = 5'd9; mi.aw_len = 8'd1;
    #1;
    check("ew_aw_ready", mi.aw_ready, 1'b1);
    check("ew_s_aw_valid", si.aw_valid, 2'b00);
    step();
    mi.aw_valid = 1'b0; mi.aw_id = 5'd4;
    mi.w_valid = 1'b1; mi.w_last = 1'b0;
    #1;
    check("ew_w_ready0", mi.w_ready, 1'b1);
    check("ew_s_w_valid", si.w_valid, 2'b00);
    step();
    mi.w_last = 1'b1;
    #1;
    check("ew_w_ready1", mi.w_ready, 1'b1);
    check("ew_b_early", mi.b_valid, 1'b0);
    step();
    mi.w_valid = 1'b0; mi.w_last = 1'b0; mi.b_ready = 1'b0;
    #1;
    check("ew_b_valid", mi.b_valid, 1'b1);
    check("ew_b_resp",  mi.b_resp, 2'b11);
    check("ew_b_id",    mi.b_id, 5'd9);
    step();
    check("ew_b_hold", mi.b_valid, 1'b1);
    mi.b_ready = 1'b1;
    step();
    #1;
    check("ew_b_done", mi.b_valid, 1'b0);
    check("ew_idle", mi.aw_ready, 1'b1);
    mi.b_ready = 1'b0;
    $display("error write: DECERR returned with id 9");

    // ---- asynchronous reset in the middle of a read burst ----
    step();
    mi.ar_valid = 1'b1; mi.ar_addr = 64'h8000_1000; mi.ar_id = 5'd6; mi.ar_len = 8'd3;
    si.ar_ready = 2'b10;
    step();
    mi.ar_valid = 1'b0; si.ar_ready = 2'b00;
    si.r_valid = 2'b10; si.r_data = {64'h55, 64'h0}; si.r_id = {5'd6, 5'd0}; si.r_last = 2'b00;
    mi.r_ready = 1'b1;
    #1;
    check("ar_rst_beat1", mi.r_valid, 1'b1);
    step();
    check("ar_rst_beat2", mi.r_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_rst_r_valid", mi.r_valid, 1'b0);
    check("ar_rst_s_r_ready", si.r_ready, 2'b00);
    check("ar_rst_ar_ready", mi.ar_ready, 1'b0);
    si.r_valid = 2'b00; si.r_data = '0; si.r_id = '0; mi.r_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mi.ar_valid = 1'b1; mi.ar_addr = 64'h1000_0000; mi.ar_id = 5'd4; mi.ar_len = 8'd0;
    #1;
    check("post_rst_ar_ready", mi.ar_ready, 1'b1);
    step();
    mi.ar_valid = 1'b0; mi.r_ready = 1'b1;
    #1;
    check("post_rst_r_valid", mi.r_valid, 1'b1);
    check("post_rst_r_last",  mi.r_last, 1'b1);
    check("post_rst_r_id",    mi.r_id, 5'd4);
    check("post_rst_r_resp",  mi.r_resp, 2'b11);
    step();
    check("post_rst_done", mi.r_valid, 1'b0);
    mi.r_ready = 1'b0;
    $display("reset abort: fresh AR completed after release");

    // ---- NS=4 build, overlapping slaves 1 and 2 ----
    si4.ar_ready = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      step();
      mi4.ar_addr = vecs4[i].addr; mi4.ar_valid = 1'b1;
      #1;
      check("ns4_s_ar_valid", si4.ar_valid, vecs4[i].exp_v);
      check("ns4_m_ar_ready", mi4.ar_ready, vecs4[i].exp_rdy);
      $display("ns4 vec %0d addr=%h slaves=%b", i, vecs4[i].addr, si4.ar_valid);
      mi4.ar_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_22051013_axi_router.md
YSYX_22051013_AXI_ROUTER -- requirements
Module: ysyx_22051013_axi_router

Interface
REQ-001 SHALL take parameter NS, default 2, meaning number of downstream slave ports (legal 2..4).
REQ-002 SHALL take parameter ADDR_W, default 64, meaning address width.
REQ-003 SHALL take parameter DATA_W, default 64, meaning data width; STRB width = DATA_W/8.
REQ-004 SHALL take parameter ID_W, default 5, meaning AXI ID width.
REQ-005 SHALL take parameter SLV_BASE, default {64'h0200_0000, 64'h8000_0000}, meaning packed per-slave base address, NS*ADDR_W bits.
REQ-006 SHALL take parameter SLV_MASK, default {64'hFFFF_FFFF_FFFF_0000, 64'hFFFF_FFFF_8000_0000}, meaning packed per-slave match mask, NS*ADDR_W bits.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-009 SHALL have port group m_aw_* (id, addr, len[7:0], size[2:0], burst[1:0], valid in; ready out), the master write-address channel.
REQ-010 SHALL have port group m_w_* (data, strb, last, valid in; ready out), the master write-data channel.
REQ-011 SHALL have port group m_b_* (id, resp[1:0], valid out; ready in), the master write-response channel.
REQ-012 SHALL have port group m_ar_* (same fields as AW) and m_r_* (id, data, resp, last, valid out; ready in), the master read channels.
REQ-013 SHALL have port group s_*, the same five channels with reversed directions, every field packed NS-wide, slice i addressing slave i.

Function
REQ-014 SHALL decode an address to slave i when (addr & SLV_MASK[i]) == SLV_BASE[i]; if several match, the lowest index wins; if none matches, the internal error slave is selected.
REQ-015 SHALL run a write FSM with states W_IDLE -> W_DATA -> W_RESP -> W_IDLE, and a read FSM with states R_IDLE -> R_DATA -> R_IDLE; the two FSMs operate independently and concurrently.
REQ-016 W_IDLE: forward m_aw_valid only to the decoded slave; m_aw_ready = that slave's aw_ready, combinationally; on the handshake, latch the selection and enter W_DATA.
REQ-017 W_DATA: route the W channel to the latched slave; m_w_ready SHALL be 0 in W_IDLE and W_RESP; a W handshake with last=1 enters W_RESP.
REQ-018 W_RESP: route the latched slave's B channel to the master; a B handshake returns to W_IDLE; no new AW is accepted before then (one outstanding write).
REQ-019 R_IDLE: AR is handled as in REQ-016; the handshake latches the selection and enters R_DATA.
REQ-020 R_DATA: route the latched slave's R channel to the master; an R handshake with last=1 returns to R_IDLE (one outstanding read).
REQ-021 Unselected slave ports SHALL drive valid/ready 0 and all payload fields 0.
REQ-022 Error slave, write path: aw_ready=1 in W_IDLE; it accepts W beats with w_ready=1 until last, then returns b_valid=1, resp=2'b11, with b_id = latched AW id.
REQ-023 Error slave, read path: returns (latched len + 1) beats with r_data=0, resp=2'b11, r_id = latched id; an 8-bit beat counter advances on each R handshake; r_last=1 iff counter == len; r_valid is held while r_ready=0.
REQ-024 Latched id/len/selection SHALL remain stable through the whole transaction regardless of m_aw/m_ar input changes.
REQ-025 Slave-originated payload (r_data, resp, id, last) SHALL pass through unmodified, with zero added latency.

Reset
REQ-026 While rst_n=0: both FSMs at IDLE, beat counter 0, selection registers 0, all master-side valid/ready outputs 0, all slave-side valids 0.
REQ-027 rst_n asserted mid-transaction SHALL abort it immediately (asynchronously); after release, the block accepts a fresh AW/AR on the first rising edge.

Verification
REQ-028 AR addr 0x8000_1000, len=3, slave 1 streams 4 beats -> 4 beats reach the master unchanged; the last beat has last=1; the FSM is back in R_IDLE the next cycle.
REQ-029 AW addr 0x0200_4000, single beat, strb 0xFF -> only slave 0 sees aw/w valid; B from slave 0 (resp 0) is returned; slave 1 stays all-zero throughout.
REQ-030 AR addr 0x1000_0000 (unmapped), id=3, len=2 -> 3 beats with data 0, resp 2'b11, id 3, last on beat 3; r_ready toggling stalls without losing beats.
REQ-031 Simultaneous AW to slave 0 and AR to slave 1 -> both proceed concurrently; a second AW during W_RESP gets m_aw_ready=0 until B completes.
REQ-032 rst_n pulled low in R_DATA after beat 1 of 4 -> all outputs 0 at once; after release, a new AR completes normally.
REQ-033 NS=4 build with overlapping masks on slaves 1 and 2 -> an address matching both routes to slave 1.
